alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer that shares a single 4-bit, 16-opcode ALU datapath.
- Accepts one operation at a time through a valid/ready request handshake.
- Registers the operands, evaluates the operation, and returns an 8-bit result to the winning requester through a valid/ready response handshake.
- Sits between the two operand-producing units and the shared combinational ALU core.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 45 ++++
 rtl/alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encoding and default widths for the ALU arbiter slice.
package alu_pkg;

  localparam int unsigned DW_DEF    = 4;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned OP_W      = 4;

  localparam logic [OP_W-1:0] OP_INC_A  = 4'h0;
  localparam logic [OP_W-1:0] OP_INC_B  = 4'h1;
  localparam logic [OP_W-1:0] OP_PASS_A = 4'h2;
  localparam logic [OP_W-1:0] OP_PASS_B = 4'h3;
  localparam logic [OP_W-1:0] OP_DEC_A  = 4'h4;
  localparam logic [OP_W-1:0] OP_MUL    = 4'h5;
  localparam logic [OP_W-1:0] OP_ADD    = 4'h6;
  localparam logic [OP_W-1:0] OP_SUB    = 4'h7;
  localparam logic [OP_W-1:0] OP_NEG_A  = 4'h8;
  localparam logic [OP_W-1:0] OP_NEG_B  = 4'h9;
  localparam logic [OP_W-1:0] OP_AND    = 4'hA;
  localparam logic [OP_W-1:0] OP_OR     = 4'hB;
  localparam logic [OP_W-1:0] OP_XOR    = 4'hC;
  localparam logic [OP_W-1:0] OP_XNOR   = 4'hD;
  localparam logic [OP_W-1:0] OP_NAND   = 4'hE;
  localparam logic [OP_W-1:0] OP_NOR    = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 16-opcode ALU; operands zero-extended to 2*DW, result modulo 2^(2*DW).
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic [OP_W-1:0] op,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic [2*DW-1:0] y_c
);

  localparam int unsigned RW = 2 * DW;

  logic [RW-1:0] ax;
  logic [RW-1:0] bx;

  assign ax = RW'(a);
  assign bx = RW'(b);

  // Opcode decode; inverting ops naturally fill the upper half with ones.
  always_comb begin
    y_c = '0;
    case (op)
      OP_INC_A:  y_c = ax + RW'(1);
      OP_INC_B:  y_c = bx + RW'(1);
      OP_PASS_A: y_c = ax;
      OP_PASS_B: y_c = bx;
      OP_DEC_A:  y_c = ax - RW'(1);
      OP_MUL:    y_c = ax * bx;
      OP_ADD:    y_c = ax + bx;
      OP_SUB:    y_c = ax - bx;
      OP_NEG_A:  y_c = -ax;
      OP_NEG_B:  y_c = -bx;
      OP_AND:    y_c = ax & bx;
      OP_OR:     y_c = ax | bx;
      OP_XOR:    y_c = ax ^ bx;
      OP_XNOR:   y_c = ~(ax ^ bx);
      OP_NAND:   y_c = ~(ax & bx);
      OP_NOR:    y_c = ~(ax | bx);
      default:   y_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sequencing one shared ALU: IDLE -> EXEC -> RESP.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DW      = DW_DEF,
  parameter logic        RR_INIT = 1'b0,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [3:0]       req_op_0,
  input  logic [3:0]       req_op_1,
  input  logic [DW-1:0]    req_a_0,
  input  logic [DW-1:0]    req_a_1,
  input  logic [DW-1:0]    req_b_0,
  input  logic [DW-1:0]    req_b_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [2*DW-1:0]  rsp_y,
  output logic             busy,
  output logic             grant_id,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int unsigned RW = 2 * DW;

  state_e           state_q,       state_d;
  logic             ptr_q,         ptr_d;
  logic             grant_q,       grant_d;
  logic [OP_W-1:0]  op_q,          op_d;
  logic [DW-1:0]    a_q,           a_d;
  logic [DW-1:0]    b_q,           b_d;
  logic [RW-1:0]    y_q,           y_d;
  logic             rsp_valid_0_q, rsp_valid_0_d;
  logic             rsp_valid_1_q, rsp_valid_1_d;
  logic             busy_q,        busy_d;
  logic [CNT_W-1:0] done_cnt_q,    done_cnt_d;

  logic          any_valid_c;
  logic          win_c;
  logic          accept_c;
  logic          rsp_hs_c;
  logic [RW-1:0] alu_y_c;

  alu_core #(.DW(DW)) u_alu_core (
    .op  (op_q),
    .a   (a_q),
    .b   (b_q),
    .y_c (alu_y_c)
  );

  // Winner selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    any_valid_c = req_valid_0 | req_valid_1;
    win_c       = (req_valid_0 & req_valid_1) ? ptr_q : req_valid_1;
    accept_c    = rst_n & (state_q == ST_IDLE) & any_valid_c;
    rsp_hs_c    = (state_q == ST_RESP) & (grant_q ? rsp_ready_1 : rsp_ready_0);
  end

  // Ready is a same-cycle grant, so it is gated by reset to stay low while rst_n is low.
  assign req_ready_0 = accept_c & ~win_c;
  assign req_ready_1 = accept_c &  win_c;

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    y_d           = y_q;
    rsp_valid_0_d = rsp_valid_0_q;
    rsp_valid_1_d = rsp_valid_1_q;
    busy_d        = busy_q;
    done_cnt_d    = done_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_valid_c) begin
          state_d = ST_EXEC;
          grant_d = win_c;
          op_d    = win_c ? req_op_1 : req_op_0;
          a_d     = win_c ? req_a_1  : req_a_0;
          b_d     = win_c ? req_b_1  : req_b_0;
          busy_d  = 1'b1;
        end
      end
      ST_EXEC: begin
        state_d       = ST_RESP;
        y_d           = alu_y_c;
        rsp_valid_0_d = ~grant_q;
        rsp_valid_1_d =  grant_q;
      end
      ST_RESP: begin
        if (rsp_hs_c) begin
          state_d       = ST_IDLE;
          ptr_d         = ~grant_q;
          done_cnt_d    = done_cnt_q + CNT_W'(1);
          rsp_valid_0_d = 1'b0;
          rsp_valid_1_d = 1'b0;
          busy_d        = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        rsp_valid_0_d = 1'b0;
        rsp_valid_1_d = 1'b0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= RR_INIT;
      grant_q       <= RR_INIT;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      y_q           <= '0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      busy_q        <= 1'b0;
      done_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      y_q           <= y_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      busy_q        <= busy_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_y       = y_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural arbitration/ALU model.
module tb_alu_arbiter;

  localparam int unsigned DW      = 4;
  localparam int unsigned CNT_W   = 16;
  localparam logic        RR_INIT = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_0 = 1'b0, req_valid_1 = 1'b0;
  logic        req_ready_0, req_ready_1;
  logic [3:0]  req_op_0 = '0, req_op_1 = '0;
  logic [3:0]  req_a_0 = '0, req_a_1 = '0, req_b_0 = '0, req_b_1 = '0;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
  logic [7:0]  rsp_y;
  logic        busy, grant_id;
  logic [15:0] done_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic        ptr_m;
  logic [15:0] cnt_m;

  always #5 clk = ~clk;

  alu_arbiter #(.DW(DW), .RR_INIT(RR_INIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_y(rsp_y), .busy(busy), .grant_id(grant_id), .done_cnt(done_cnt)
  );

  // Reference ALU: integer arithmetic on the operand values, reduced modulo 256.
  function automatic logic [7:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + 1;     1: r = b + 1;     2: r = a;          3: r = b;
      4: r = a - 1;     5: r = a * b;     6: r = a + b;      7: r = a - b;
      8: r = -a;        9: r = -b;        10: r = a & b;     11: r = a | b;
      12: r = a ^ b;    13: r = ~(a ^ b); 14: r = ~(a & b);  default: r = ~(a | b);
    endcase
    return 8'(r);
  endfunction

  function automatic logic ready_of(input int k);
    return (k == 0) ? req_ready_0 : req_ready_1;
  endfunction

  function automatic logic valid_of(input int k);
    return (k == 0) ? rsp_valid_0 : rsp_valid_1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int k, input logic v, input logic [3:0] op,
                           input logic [3:0] a, input logic [3:0] b);
    if (k == 0) begin
      req_valid_0 = v; req_op_0 = op; req_a_0 = a; req_b_0 = b;
    end else begin
      req_valid_1 = v; req_op_1 = op; req_a_1 = a; req_b_1 = b;
    end
  endtask

  task automatic set_rsp_ready(input int k, input logic v);
    if (k == 0) rsp_ready_0 = v;
    else        rsp_ready_1 = v;
  endtask

  // Runs one transaction from requester k (other idle unless other_req) and reports observations.
  task automatic txn(input int k, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                     input int hold, input bit other_req,
                     output logic rdy, output logic gid, output logic exec_ok, output logic v_on,
                     output logic [7:0] y, output logic hold_ok, output logic v_after);
    drive_req(k, 1'b1, op, a, b);
    #1;
    rdy = ready_of(k) & ~ready_of(1 - k);
    step();
    drive_req(k, 1'b0, 4'h0, 4'h0, 4'h0);
    gid = grant_id;
    exec_ok = busy & ~rsp_valid_0 & ~rsp_valid_1;
    step();
    v_on = valid_of(k) & ~valid_of(1 - k);
    y = rsp_y;
    hold_ok = 1'b1;
    if (other_req) drive_req(1 - k, 1'b1, 4'h3, 4'h1, 4'h2);
    for (int i = 0; i < hold; i++) begin
      set_rsp_ready(1 - k, 1'b1);
      step();
      if (rsp_y !== y || valid_of(k) !== 1'b1 || busy !== 1'b1 ||
          req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) hold_ok = 1'b0;
    end
    set_rsp_ready(1 - k, 1'b0);
    set_rsp_ready(k, 1'b1);
    step();
    set_rsp_ready(k, 1'b0);
    if (other_req) drive_req(1 - k, 1'b0, 4'h0, 4'h0, 4'h0);
    v_after = rsp_valid_0 | rsp_valid_1 | busy;
    ptr_m = (k == 0) ? 1'b1 : 1'b0;
    cnt_m = cnt_m + 16'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_req(0, 1'b1, 4'h5, 4'hF, 4'hF);
    #3;
    vectors++;
    if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b want 00000", {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy});
    end
    vectors++;
    if ({grant_id, rsp_y, done_cnt} !== {RR_INIT, 8'h00, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_data: got %h/%h/%h want %h/00/0000", grant_id, rsp_y, done_cnt, RR_INIT);
    end
    drive_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    ptr_m = RR_INIT;
    cnt_m = 16'h0000;
  endtask

  task automatic test_single();
    logic rdy, gid, exec_ok, v_on, hold_ok, v_after;
    logic [7:0] y;
    txn(0, 4'h5, 4'hF, 4'hF, 0, 1'b0, rdy, gid, exec_ok, v_on, y, hold_ok, v_after);
    vectors++; if (rdy !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", rdy); end
    vectors++; if (gid !== 1'b0) begin miscompares++; $display("FAIL single_grant: got %b want 0", gid); end
    vectors++; if (exec_ok !== 1'b1) begin miscompares++; $display("FAIL single_exec: got %b want 1", exec_ok); end
    vectors++; if (v_on !== 1'b1) begin miscompares++; $display("FAIL single_rsp_valid: got %b want 1", v_on); end
    vectors++; if (y !== 8'hE1) begin miscompares++; $display("FAIL single_y: got %h want e1", y); end
    vectors++; if (v_after !== 1'b0) begin miscompares++; $display("FAIL single_idle: got %b want 0", v_after); end
    vectors++; if (done_cnt !== cnt_m) begin miscompares++; $display("FAIL single_cnt: got %h want %h", done_cnt, cnt_m); end
  endtask

  task automatic test_both_valid();
    logic w;
    logic [3:0] op [2];
    logic [3:0] a [2];
    logic [3:0] b [2];
    op[0] = 4'h7; a[0] = 4'h3; b[0] = 4'h5;
    op[1] = 4'h4; a[1] = 4'h0; b[1] = 4'h0;
    drive_req(0, 1'b1, op[0], a[0], b[0]);
    drive_req(1, 1'b1, op[1], a[1], b[1]);
    for (int n = 0; n < 2; n++) begin
      w = ptr_m;
      #1;
      vectors++;
      if (req_ready_0 !== ~w || req_ready_1 !== w) begin
        miscompares++; $display("FAIL both_ready%0d: got %b%b want winner %b", n, req_ready_0, req_ready_1, w);
      end
      step();
      drive_req(int'(w), 1'b0, 4'h0, 4'h0, 4'h0);
      vectors++; if (grant_id !== w) begin miscompares++; $display("FAIL both_grant%0d: got %b want %b", n, grant_id, w); end
      step();
      vectors++;
      if (valid_of(int'(w)) !== 1'b1 || rsp_y !== ref_alu(int'(op[w]), int'(a[w]), int'(b[w]))) begin
        miscompares++; $display("FAIL both_y%0d: got %b/%h want 1/%h", n, valid_of(int'(w)), rsp_y,
                                ref_alu(int'(op[w]), int'(a[w]), int'(b[w])));
      end
      set_rsp_ready(int'(w), 1'b1);
      step();
      set_rsp_ready(int'(w), 1'b0);
      ptr_m = ~w;
      cnt_m = cnt_m + 16'd1;
    end
    vectors++; if (done_cnt !== cnt_m) begin miscompares++; $display("FAIL both_cnt: got %h want %h", done_cnt, cnt_m); end
  endtask

  task automatic test_backpressure();
    logic rdy, gid, exec_ok, v_on, hold_ok, v_after;
    logic [7:0] y;
    txn(1, 4'hD, 4'h5, 4'h3, 4, 1'b1, rdy, gid, exec_ok, v_on, y, hold_ok, v_after);
    vectors++; if (gid !== 1'b1) begin miscompares++; $display("FAIL bp_grant: got %b want 1", gid); end
    vectors++; if (y !== 8'hF9) begin miscompares++; $display("FAIL bp_y: got %h want f9", y); end
    vectors++; if (hold_ok !== 1'b1) begin miscompares++; $display("FAIL bp_hold: got %b want 1", hold_ok); end
    vectors++; if (v_after !== 1'b0) begin miscompares++; $display("FAIL bp_release: got %b want 0", v_after); end
    vectors++; if (done_cnt !== cnt_m) begin miscompares++; $display("FAIL bp_cnt: got %h want %h", done_cnt, cnt_m); end
  endtask

  task automatic test_ops();
    logic rdy, gid, exec_ok, v_on, hold_ok, v_after;
    logic [7:0] y;
    int k;
    logic [3:0] op, a, b;
    for (int i = 0; i < 19; i++) begin
      case (i)
        0: begin k = 0; op = 4'h8; a = 4'h1; b = 4'h0; end
        1: begin k = 0; op = 4'hF; a = 4'h0; b = 4'h0; end
        2: begin k = 1; op = 4'hA; a = 4'hC; b = 4'hA; end
        default: begin
          k = int'($urandom_range(0, 1)); op = 4'(i - 3);
          a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
        end
      endcase
      txn(k, op, a, b, 0, 1'b0, rdy, gid, exec_ok, v_on, y, hold_ok, v_after);
      vectors++;
      if (y !== ref_alu(int'(op), int'(a), int'(b)) || v_on !== 1'b1) begin
        miscompares++; $display("FAIL op%h_y: a=%h b=%h got %b/%h want 1/%h", op, a, b, v_on, y,
                                ref_alu(int'(op), int'(a), int'(b)));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, gid, exec_ok, v_on, hold_ok, v_after;
    logic [7:0] y;
    logic stray;
    txn(0, 4'h2, 4'h9, 4'h1, 0, 1'b0, rdy, gid, exec_ok, v_on, y, hold_ok, v_after);
    drive_req(1, 1'b1, 4'h6, 4'h7, 4'h7);
    step();
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, busy, grant_id, rsp_y, done_cnt} !==
        {5'b0, RR_INIT, 8'h00, 16'h0000}) begin
      miscompares++;
      $display("FAIL midrst_outputs: got %b%b%b%b%b/%b/%h/%h want 00000/%b/00/0000", req_ready_0, req_ready_1,
               rsp_valid_0, rsp_valid_1, busy, grant_id, rsp_y, done_cnt, RR_INIT);
    end
    drive_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = RR_INIT;
    cnt_m = 16'h0000;
    stray = 1'b0;
    repeat (3) begin
      step();
      stray = stray | rsp_valid_0 | rsp_valid_1 | busy;
    end
    vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL midrst_stray: got %b want 0", stray); end
    drive_req(0, 1'b1, 4'h0, 4'h4, 4'h0);
    drive_req(1, 1'b1, 4'h1, 4'h0, 4'h4);
    #1;
    vectors++;
    if ({req_ready_0, req_ready_1} !== (RR_INIT ? 2'b01 : 2'b10)) begin
      miscompares++; $display("FAIL midrst_ptr: got %b%b want winner %b", req_ready_0, req_ready_1, RR_INIT);
    end
    step();
    drive_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
    drive_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
    step();
    set_rsp_ready(int'(RR_INIT), 1'b1);
    step();
    set_rsp_ready(int'(RR_INIT), 1'b0);
    ptr_m = ~RR_INIT;
    cnt_m = cnt_m + 16'd1;
    vectors++; if (done_cnt !== 16'h0001) begin miscompares++; $display("FAIL midrst_cnt: got %h want 0001", done_cnt); end
  endtask

  task automatic test_wrap();
    logic rdy, gid, exec_ok, v_on, hold_ok, v_after;
    logic [7:0] y;
    force dut.done_cnt_q = 16'hFFFF;
    step();
    release dut.done_cnt_q;
    #1;
    cnt_m = 16'hFFFF;
    vectors++; if (done_cnt !== cnt_m) begin miscompares++; $display("FAIL wrap_preset: got %h want ffff", done_cnt); end
    txn(int'(ptr_m), 4'h6, 4'h2, 4'h3, 0, 1'b0, rdy, gid, exec_ok, v_on, y, hold_ok, v_after);
    vectors++; if (done_cnt !== 16'h0000) begin miscompares++; $display("FAIL wrap_cnt: got %h want 0000", done_cnt); end
  endtask

  task automatic test_random();
    int pat, w, hold;
    logic [3:0] op [2];
    logic [3:0] a [2];
    logic [3:0] b [2];
    logic [7:0] exp_y;
    for (int n = 0; n < 40; n++) begin
      pat = int'($urandom_range(1, 3));
      for (int k = 0; k < 2; k++) begin
        op[k] = 4'($urandom_range(0, 15)); a[k] = 4'($urandom_range(0, 15)); b[k] = 4'($urandom_range(0, 15));
        drive_req(k, pat[k], op[k], a[k], b[k]);
      end
      w = (pat == 3) ? int'(ptr_m) : ((pat == 1) ? 0 : 1);
      exp_y = ref_alu(int'(op[w]), int'(a[w]), int'(b[w]));
      #1;
      vectors++;
      if (ready_of(w) !== 1'b1 || ready_of(1 - w) !== 1'b0) begin
        miscompares++; $display("FAIL rnd%0d_ready: got %b%b want winner %0d", n, req_ready_0, req_ready_1, w);
      end
      step();
      drive_req(0, 1'b0, 4'h0, 4'h0, 4'h0);
      drive_req(1, 1'b0, 4'h0, 4'h0, 4'h0);
      vectors++; if (grant_id !== 1'(w)) begin miscompares++; $display("FAIL rnd%0d_grant: got %b want %0d", n, grant_id, w); end
      step();
      vectors++;
      if (valid_of(w) !== 1'b1 || rsp_y !== exp_y) begin
        miscompares++; $display("FAIL rnd%0d_y: got %b/%h want 1/%h", n, valid_of(w), rsp_y, exp_y);
      end
      hold = int'($urandom_range(0, 2));
      for (int i = 0; i < hold; i++) begin
        set_rsp_ready(1 - w, 1'($urandom_range(0, 1)));
        step();
      end
      set_rsp_ready(1 - w, 1'b0);
      set_rsp_ready(w, 1'b1);
      step();
      set_rsp_ready(w, 1'b0);
      ptr_m = (w == 0) ? 1'b1 : 1'b0;
      cnt_m = cnt_m + 16'd1;
      vectors++; if (done_cnt !== cnt_m) begin miscompares++; $display("FAIL rnd%0d_cnt: got %h want %h", n, done_cnt, cnt_m); end
    end
  endtask

  initial begin
    test_reset();
    test_both_valid();
    test_single();
    test_backpressure();
    test_ops();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
